nested_fanout_buffer: RTL and testbench
=======================================

Name: nested_fanout_buffer

Overview:
- Upstream feeder for the nested true/complement distribution scope: accepts one word stream with a valid/ready handshake.
- Forks each accepted word into two independently drained lanes: lane a carries the word unchanged, lane b carries its bitwise complement.
- Each lane has its own DEPTH-entry FIFO, so the consumers can run out of step by up to DEPTH words.

Parameters:
WIDTH, 1, data word width in bits (>=1)
DEPTH, 2, entries per lane FIFO (power of two, >=2)
CW, $clog2(DEPTH+1), width of the level outputs (derived, not overridden)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream word valid
in_ready  output  1  block can accept a word this cycle
in_data  input  WIDTH  upstream word
a_valid  output  1  lane a head valid
a_ready  input  1  lane a consumer ready
a_data  output  WIDTH  lane a head word (true polarity)
b_valid  output  1  lane b head valid
b_ready  input  1  lane b consumer ready
b_data  output  WIDTH  lane b head word (complemented)
a_level  output  CW  lane a occupancy, 0..DEPTH
b_level  output  CW  lane b occupancy, 0..DEPTH

Behaviour:
- Reset (async assert, sync release):
  - both FIFOs empty; read/write pointers = 0; levels = 0
  - a_valid = b_valid = 0; a_data = b_data = 0; in_ready = 1
- Storage per lane: a circular buffer with write pointer, read pointer and count register. Pointers wrap DEPTH-1 -> 0.
- in_ready = (a_level != DEPTH) && (b_level != DEPTH).
  - Derived only from registered counts.
  - No combinational path from a_ready/b_ready or in_valid to in_ready.
- Accept = in_valid && in_ready. On accept:
  - in_data is written to lane a.
  - ~in_data is written to lane b in the same cycle.
  - A word is never written to only one lane.
- Pop lane x = x_valid && x_ready. The read pointer advances and the count decrements.
- Same-cycle push and pop on a lane: count unchanged, both pointers advance. Legal only when not full, because a full lane blocks the push. There is no bypass, even when a pop frees an entry that cycle.
- x_valid = (x_level != 0).
- x_data = head entry when x_valid, else all-zero.
- x_data is held stable while x_valid && !x_ready.
- Latency: a word accepted at edge N is visible on both lanes at the head after edge N, if that lane was empty. Minimum latency is 1 cycle; there is no same-cycle pass-through.
- Lanes drain independently. Lane levels may differ by at most DEPTH.
- Ordering: each lane delivers words in acceptance order, with no loss or duplication.
- x_ready while !x_valid: ignored.
- in_valid while !in_ready: word not taken. Upstream must hold it (standard valid/ready).
- Reset asserted mid-stream: both lanes flush immediately (async); in-flight contents are discarded. The first accept after release lands at pointer 0.
- No X propagation: all registers, including storage entries, are reset to 0.

Test Plan:
- Reset, then idle -> in_ready=1, a_valid=b_valid=0, a_data=b_data=0, levels=0.
- WIDTH=4. Accept 4'hA with a_ready=b_ready=0 -> next cycle a_data=4'hA, b_data=4'h5, both valid, levels=1. Assert both readys for 1 cycle -> both empty.
- DEPTH=2. Hold b_ready=0, a_ready=1, push 4'h1, 4'h2 back-to-back:
  - a delivers 1, 2; b_level reaches 2 and in_ready drops to 0.
  - A third word 4'h3 is held until b pops once, then accepted.
  - b later yields 4'hE, 4'hD, 4'hC.
- Full lane with b_ready=1 and in_valid=1 in the same cycle -> no accept that cycle (in_ready=0). Accept occurs the following cycle, and b_level returns to 2.
- Stream 10 words (0..9) with a_ready toggling every cycle and b_ready=1 -> pointers wrap several times. a yields 0..9 in order; b yields ~0..~9 in order; no drop or duplicate.
- Push 2 words, assert rst_n=0 mid-cycle with a_ready=0 -> valids and levels go to 0 without waiting for a clock edge. After release, push 4'h7 -> a_data=4'h7 next cycle, with no stale data.

Source files
------------

// File: rtl/nested_fanout_buffer.sv
// Valid/ready word splitter: every accepted word enters lane a unchanged and lane b inverted.
// Each lane has its own circular FIFO, so the two consumers can drain at different rates.
module nested_fanout_buffer #(
  parameter  int WIDTH = 1,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] b_data,
  output logic [CW-1:0]    a_level,
  output logic [CW-1:0]    b_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LANES = 2;

  // Index 0 is lane a (true polarity), index 1 is lane b (complement).
  logic [WIDTH-1:0] mem_q    [LANES][DEPTH];
  logic [WIDTH-1:0] mem_d    [LANES][DEPTH];
  logic [PW-1:0]    wr_ptr_q [LANES];
  logic [PW-1:0]    wr_ptr_d [LANES];
  logic [PW-1:0]    rd_ptr_q [LANES];
  logic [PW-1:0]    rd_ptr_d [LANES];
  logic [CW-1:0]    cnt_q    [LANES];
  logic [CW-1:0]    cnt_d    [LANES];

  logic [WIDTH-1:0] lane_wdata [LANES];
  logic [LANES-1:0] pop;
  logic             accept;

  // Taken only from registered counts, so no ready or valid input reaches in_ready.
  assign in_ready = (cnt_q[0] != CW'(DEPTH)) && (cnt_q[1] != CW'(DEPTH));
  assign accept   = in_valid && in_ready;

  assign lane_wdata[0] = in_data;
  assign lane_wdata[1] = ~in_data;

  assign a_valid = (cnt_q[0] != '0);
  assign b_valid = (cnt_q[1] != '0);
  assign a_data  = a_valid ? mem_q[0][rd_ptr_q[0]] : '0;
  assign b_data  = b_valid ? mem_q[1][rd_ptr_q[1]] : '0;
  assign a_level = cnt_q[0];
  assign b_level = cnt_q[1];

  assign pop[0] = a_valid && a_ready;
  assign pop[1] = b_valid && b_ready;

  // NOTE: every always_comb output is given its held value first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    for (int l = 0; l < LANES; l++) begin
      // The push is gated by both lanes together, so a word can never land in just one lane.
      if (accept) begin
        mem_d[l][wr_ptr_q[l]] = lane_wdata[l];
        wr_ptr_d[l]           = wr_ptr_q[l] + PW'(1);
      end
      if (pop[l]) begin
        rd_ptr_d[l] = rd_ptr_q[l] + PW'(1);
      end
      cnt_d[l] = cnt_q[l] + CW'(accept) - CW'(pop[l]);
    end
  end

  // NOTE: the storage array is reset with the pointers, which keeps X out of the data path after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < LANES; l++) begin
        for (int e = 0; e < DEPTH; e++) begin
          mem_q[l][e] <= '0;
        end
        wr_ptr_q[l] <= '0;
        rd_ptr_q[l] <= '0;
        cnt_q[l]    <= '0;
      end
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_nested_fanout_buffer.sv
// Directed bench for nested_fanout_buffer at WIDTH=4, DEPTH=2.
// Inputs change 1 ns after each rising edge; outputs are read at that same point.
module tb_nested_fanout_buffer;

  localparam int WIDTH = 4;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             a_valid, a_ready;
  logic [WIDTH-1:0] a_data;
  logic             b_valid, b_ready;
  logic [WIDTH-1:0] b_data;
  logic [CW-1:0]    a_level, b_level;

  int errors = 0;
  int checks = 0;

  nested_fanout_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data (in_data),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .a_data  (a_data),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .b_data  (b_data),
    .a_level (a_level),
    .b_level (b_level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; a_ready = 1'b0; b_ready = 1'b0;
    #2;
    @(negedge clk) rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_a_valid: got %b expected 0", a_valid); end
    checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL reset_b_valid: got %b expected 0", b_valid); end
    checks++; if (a_data !== 4'h0) begin errors++; $display("FAIL reset_a_data: got %h expected 0", a_data); end
    checks++; if (b_data !== 4'h0) begin errors++; $display("FAIL reset_b_data: got %h expected 0", b_data); end
    checks++; if (a_level !== 2'd0) begin errors++; $display("FAIL reset_a_level: got %0d expected 0", a_level); end
    checks++; if (b_level !== 2'd0) begin errors++; $display("FAIL reset_b_level: got %0d expected 0", b_level); end
  endtask

  task automatic test_single_word();
    in_valid = 1'b1; in_data = 4'hA; a_ready = 1'b0; b_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    checks++; if (a_data !== 4'hA) begin errors++; $display("FAIL single_a_data: got %h expected a", a_data); end
    checks++; if (b_data !== 4'h5) begin errors++; $display("FAIL single_b_data: got %h expected 5", b_data); end
    checks++; if ({a_valid, b_valid} !== 2'b11) begin errors++; $display("FAIL single_valids: got %b expected 11", {a_valid, b_valid}); end
    checks++; if ({a_level, b_level} !== {2'd1, 2'd1}) begin errors++; $display("FAIL single_levels: got %0d/%0d expected 1/1", a_level, b_level); end
    a_ready = 1'b1; b_ready = 1'b1;
    tick();
    a_ready = 1'b0; b_ready = 1'b0;
    checks++; if ({a_valid, b_valid} !== 2'b00) begin errors++; $display("FAIL single_drained_valids: got %b expected 00", {a_valid, b_valid}); end
    checks++; if ({a_level, b_level} !== {2'd0, 2'd0}) begin errors++; $display("FAIL single_drained_levels: got %0d/%0d expected 0/0", a_level, b_level); end
  endtask

  task automatic test_back_to_back();
    a_ready = 1'b1; b_ready = 1'b0;
    in_valid = 1'b1; in_data = 4'h1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_empty: got %b expected 1", in_ready); end
    tick();  // word 1 accepted into both lanes
    checks++; if (a_data !== 4'h1) begin errors++; $display("FAIL b2b_a_first: got %h expected 1", a_data); end
    in_data = 4'h2;
    tick();  // word 2 accepted, lane a pops 1
    checks++; if (a_data !== 4'h2) begin errors++; $display("FAIL b2b_a_second: got %h expected 2", a_data); end
    checks++; if (b_level !== 2'd2) begin errors++; $display("FAIL b2b_b_full: got %0d expected 2", b_level); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready_full: got %b expected 0", in_ready); end
    in_data = 4'h3;
    tick();  // lane b full: word 3 must be held; lane a pops 2
    checks++; if (b_level !== 2'd2) begin errors++; $display("FAIL b2b_held_b_level: got %0d expected 2", b_level); end
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL b2b_held_a_empty: got %b expected 0", a_valid); end
    checks++; if (b_data !== 4'hE) begin errors++; $display("FAIL b2b_b_head: got %h expected e", b_data); end
    // Pop and offered push in the same cycle on a full lane: no bypass.
    b_ready = 1'b1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_no_bypass_ready: got %b expected 0", in_ready); end
    tick();
    b_ready = 1'b0;
    checks++; if (b_level !== 2'd1) begin errors++; $display("FAIL b2b_after_pop_level: got %0d expected 1", b_level); end
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_accept_a: got %b expected 0", a_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_back: got %b expected 1", in_ready); end
    tick();  // word 3 accepted now
    in_valid = 1'b0;
    checks++; if (b_level !== 2'd2) begin errors++; $display("FAIL b2b_refill_level: got %0d expected 2", b_level); end
    checks++; if (a_data !== 4'h3) begin errors++; $display("FAIL b2b_a_third: got %h expected 3", a_data); end
    b_ready = 1'b1;
    checks++; if (b_data !== 4'hD) begin errors++; $display("FAIL b2b_b_second: got %h expected d", b_data); end
    tick();
    checks++; if (b_data !== 4'hC) begin errors++; $display("FAIL b2b_b_third: got %h expected c", b_data); end
    tick();
    checks++; if ({a_valid, b_valid} !== 2'b00) begin errors++; $display("FAIL b2b_drained: got %b expected 00", {a_valid, b_valid}); end
    a_ready = 1'b0; b_ready = 1'b0;
  endtask

  task automatic test_stream_wrap();
    int next_in = 0;
    int exp_a   = 0;
    int exp_b   = 0;
    int cyc     = 0;
    b_ready = 1'b1;
    while ((exp_a < 10 || exp_b < 10) && cyc < 200) begin
      in_valid = (next_in < 10);
      in_data  = WIDTH'(next_in);
      a_ready  = cyc[0];
      if (a_valid && a_ready) begin
        checks++;
        if (a_data !== WIDTH'(exp_a)) begin errors++; $display("FAIL stream_a_word%0d: got %h expected %h", exp_a, a_data, WIDTH'(exp_a)); end
        exp_a++;
      end
      if (b_valid && b_ready) begin
        checks++;
        if (b_data !== ~WIDTH'(exp_b)) begin errors++; $display("FAIL stream_b_word%0d: got %h expected %h", exp_b, b_data, ~WIDTH'(exp_b)); end
        exp_b++;
      end
      if (in_valid && in_ready) next_in++;
      tick();
      cyc++;
    end
    in_valid = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
    checks++; if (exp_a != 10 || exp_b != 10) begin errors++; $display("FAIL stream_timeout: got %0d/%0d words expected 10/10", exp_a, exp_b); end
    checks++; if ({a_valid, b_valid} !== 2'b00) begin errors++; $display("FAIL stream_no_duplicate: got valids %b expected 00", {a_valid, b_valid}); end
  endtask

  task automatic test_reset_midstream();
    a_ready = 1'b0; b_ready = 1'b0;
    in_valid = 1'b1; in_data = 4'h5;
    tick();
    in_data = 4'h6;
    tick();
    in_valid = 1'b0;
    checks++; if (a_level !== 2'd2) begin errors++; $display("FAIL midrst_prefill: got %0d expected 2", a_level); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({a_valid, b_valid} !== 2'b00) begin errors++; $display("FAIL midrst_async_valids: got %b expected 00", {a_valid, b_valid}); end
    checks++; if ({a_level, b_level} !== {2'd0, 2'd0}) begin errors++; $display("FAIL midrst_async_levels: got %0d/%0d expected 0/0", a_level, b_level); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
    @(negedge clk) rst_n = 1'b1;
    tick();
    in_valid = 1'b1; in_data = 4'h7;
    tick();
    in_valid = 1'b0;
    checks++; if (a_data !== 4'h7) begin errors++; $display("FAIL midrst_a_data: got %h expected 7", a_data); end
    checks++; if (b_data !== 4'h8) begin errors++; $display("FAIL midrst_b_data: got %h expected 8", b_data); end
    checks++; if (a_level !== 2'd1) begin errors++; $display("FAIL midrst_a_level: got %0d expected 1", a_level); end
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_stale: got %b expected 0", a_valid); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stream_wrap();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
